larsen_scanner_pwm: RTL and testbench
=====================================

Name: larsen_scanner_pwm

Overview:
- Parametrised successor to the board's fixed 8-LED scanner.
- Moves a single "head" position across NUM_LEDS outputs, either bouncing between the ends or wrapping around.
- Each LED holds a brightness level that decays after the head passes. The LEDs are driven through a shared free-running PWM, which gives a fading comet tail.
- Sits directly on the LED pins of the dev-board top level, clocked from hwclk.

Parameters:
- NUM_LEDS, 8: number of LED outputs; legal range is >= 2.
- DIV_BITS, 19: the step tick fires once every 2^DIV_BITS enabled hwclk cycles; legal range is >= 1.
- PWM_BITS, 4: width of the brightness values and of the PWM counter; MAX = 2^PWM_BITS-1.

Ports:
- hwclk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: 1 = the scan advances; 0 = the scan state freezes.
- wrap_mode, input, 1: 0 = bounce, 1 = wrap (0..N-1, then back to 0).
- led, output, NUM_LEDS: registered LED drive; led[0] is the leftmost LED.
- pos, output, clog2(NUM_LEDS): current head index.
- step, output, 1: one-cycle pulse on every cycle where the scan advances.

Behaviour:
- Reset (async assert, rst_n=0):
  - divider=0, pwm_cnt=0, pos=0, dir=up.
  - bright[0]=MAX; all other bright=0.
  - led=0, step=0.
- Divider:
  - DIV_BITS-wide counter; increments each cycle only while enable=1.
  - tick = enable AND divider==all-ones. The divider wraps to 0 on that same cycle.
  - step is a register loaded with tick, so it goes high the cycle after tick, aligned with the new pos.
- Enable low:
  - divider, pos, dir and bright all hold.
  - pwm_cnt keeps running, so the LEDs keep showing the frozen image.
- On tick, head movement:
  - Bounce, dir=up: if pos==N-1 then dir<=down and pos<=N-2; otherwise pos<=pos+1.
  - Bounce, dir=down: if pos==0 then dir<=up and pos<=1; otherwise pos<=pos-1.
  - Bounce period is 2*(N-1) ticks. The end LEDs are each visited once per period, with no double dwell.
  - Wrap: pos<=(pos==N-1)?0:pos+1, and dir<=up.
  - Switching wrap_mode mid-scan takes effect at the next tick; no other action is taken.
  - Leaving wrap into bounce continues upward from the current pos.
- On tick, brightness:
  - For every i: bright[i] <= (i==next_pos) ? MAX : bright[i]>>1.
  - Decay is a logical right shift and saturates at 0.
- PWM:
  - pwm_cnt is PWM_BITS wide, free-running, and increments every cycle (including when enable=0).
  - Each cycle: led[i] <= (bright[i] > pwm_cnt).
  - Duty is therefore bright/2^PWM_BITS. MAX gives an LED that is on 2^PWM_BITS-1 cycles out of every 2^PWM_BITS; 0 gives an LED that is always off.
- Latency:
  - The pos/bright change becomes visible on led one cycle after the update (output register).
- Reset mid-operation:
  - Returns immediately to the reset state; no partial tick completes.
  - After release, the first tick occurs 2^DIV_BITS enabled cycles later.

Optional Feature:
LARSEN_TAIL_EN
- Defined: decaying-tail behaviour exactly as specified above.
- Undefined: no tail.
  - No bright array and no PWM counter are built.
  - led is a registered one-hot of pos: led[i] <= (i==pos). After reset, led becomes 1 on bit 0 one cycle after rst_n deasserts.
  - divider, pos, dir, step, enable and wrap_mode behave identically to the tail build.

Test Plan:
1. Reset with NUM_LEDS=8, DIV_BITS=2, PWM_BITS=4, enable=1, wrap=0.
   - During reset: led=0, pos=0, step=0.
   - First step pulse occurs 4 cycles after release.
   - Pos sequence over successive ticks is 1,2,...,7,6,...,0,1 (period 14).
2. Wrap mode, same parameters.
   - Pos sequence is 0..7, then 0.
   - Switching wrap=1 while moving down at pos=3 gives next pos=4; switching back to 0 gives next pos=5.
3. Tail decay, sampled right after the tick that moves the head to pos 3 (bounce).
   - bright[3..0] = 15, 7, 3, 1.
   - Over 16 cycles, led[2] is high for exactly 7 cycles and led[3] for exactly 15.
4. Freeze: enable=0 for 100 cycles mid-scan.
   - pos, bright and divider are unchanged; no step pulse.
   - The led duty pattern persists.
   - After re-enable, the next tick occurs after the remaining divider count.
5. Assert rst_n mid-scan at pos=5, dir=down.
   - Outputs return to reset values asynchronously (before the next hwclk edge).
   - After release, the scan restarts at 0 going up.
6. Build without LARSEN_TAIL_EN.
   - led is one-hot of pos every cycle (one-cycle lag).
   - Exactly one bit is set after the first post-reset cycle.

Source files
------------

// File: rtl/larsen_scanner_pwm_if.sv
// larsen_scanner_pwm_if: scanner control inputs and LED/position/step outputs.
interface larsen_scanner_pwm_if #(
    parameter int NUM_LEDS = 8
);
    logic                        enable;
    logic                        wrap_mode;
    logic [NUM_LEDS-1:0]         led;
    logic [$clog2(NUM_LEDS)-1:0] pos;
    logic                        step;
    modport master (output enable, wrap_mode, input led, pos, step);
    modport slave (input enable, wrap_mode, output led, pos, step);
endinterface

// File: rtl/larsen_scanner_pwm.sv
// larsen_scanner_pwm: bouncing/wrapping LED head; define LARSEN_TAIL_EN for a PWM-faded decaying tail,
// otherwise led is a registered one-hot of the head position.
module larsen_scanner_pwm #(
    parameter int NUM_LEDS = 8,
    parameter int DIV_BITS = 19,
    parameter int PWM_BITS = 4
) (
    input logic hwclk,
    input logic rst_n,
    larsen_scanner_pwm_if.slave bus
);
    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);
    typedef enum logic {UP, DOWN} dir_e;
    dir_e dir_q, dir_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic step_q, tick;
    always_comb begin
        tick = bus.enable && (&div_q);
        div_d = bus.enable ? div_q + DIV_BITS'(1) : div_q;
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick) begin
            if (bus.wrap_mode) begin
                pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
                dir_d = UP;
            end else if (dir_q == UP) begin
                pos_d = (pos_q == LAST) ? LAST - PW'(1) : pos_q + PW'(1);
                dir_d = (pos_q == LAST) ? DOWN : UP;
            end else begin
                pos_d = (pos_q == '0) ? PW'(1) : pos_q - PW'(1);
                dir_d = (pos_q == '0) ? UP : DOWN;
            end
        end
    end
`ifdef LARSEN_TAIL_EN
    localparam logic [PWM_BITS-1:0] MAX = '1;
    logic [PWM_BITS-1:0] bright_q [NUM_LEDS];
    logic [PWM_BITS-1:0] bright_d [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_q;
    // The head lands at full brightness; everything else halves on each tick.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            bright_d[i] = !tick ? bright_q[i] : (pos_d == PW'(i)) ? MAX : bright_q[i] >> 1;
            led_d[i] = bright_q[i] > pwm_q;
        end
    end
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) bright_q[i] <= (i == 0) ? MAX : '0;
        end else begin
            pwm_q <= pwm_q + PWM_BITS'(1);
            bright_q <= bright_d;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) led_d[i] = (pos_q == PW'(i));
    end
`endif
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            pos_q <= '0;
            dir_q <= UP;
            step_q <= 1'b0;
            led_q <= '0;
        end else begin
            div_q <= div_d;
            pos_q <= pos_d;
            dir_q <= dir_d;
            step_q <= tick;
            led_q <= led_d;
        end
    end
    assign bus.led = led_q;
    assign bus.pos = pos_q;
    assign bus.step = step_q;
endmodule

// File: tb/tb_larsen_scanner_pwm.sv
// tb_larsen_scanner_pwm: directed scenarios plus randomized run against a phase-based reference model.
module tb_larsen_scanner_pwm;
    localparam int N = 8, D = 2, P = 4;
    localparam int DIVN = 1 << D, PWMN = 1 << P, MAXB = PWMN - 1;
    logic hwclk = 0, rst_n = 1;
    larsen_scanner_pwm_if #(.NUM_LEDS(N)) bus();
    larsen_scanner_pwm #(.NUM_LEDS(N), .DIV_BITS(D), .PWM_BITS(P)) dut (
        .hwclk(hwclk), .rst_n(rst_n), .bus(bus)
    );
    always #5 hwclk = ~hwclk;
    int n_tests = 0, n_fail = 0;
    // Bounce is a triangle wave over phase 0..2N-3; wrap re-enters at phase == pos.
    int m_div, m_ph;
    bit m_step;
    logic [N-1:0] m_led;
`ifdef LARSEN_TAIL_EN
    int m_pwm;
    int m_br [N];
`endif

    function automatic int pos_of(int ph);
        return ph < N ? ph : 2 * N - 2 - ph;
    endfunction

    task automatic model_reset();
        m_div = 0; m_ph = 0; m_step = 0; m_led = '0;
`ifdef LARSEN_TAIL_EN
        m_pwm = 0;
        for (int i = 0; i < N; i++) m_br[i] = (i == 0) ? MAXB : 0;
`endif
    endtask

    task automatic model_edge();
        logic [N-1:0] l;
        bit tick;
        for (int i = 0; i < N; i++) begin
`ifdef LARSEN_TAIL_EN
            l[i] = m_br[i] > m_pwm;
`else
            l[i] = pos_of(m_ph) == i;
`endif
        end
        tick = bus.enable && m_div == DIVN - 1;
        m_step = tick;
        if (bus.enable) m_div = (m_div + 1) % DIVN;
        if (tick) m_ph = bus.wrap_mode ? (pos_of(m_ph) + 1) % N : (m_ph + 1) % (2 * N - 2);
`ifdef LARSEN_TAIL_EN
        m_pwm = (m_pwm + 1) % PWMN;
        if (tick) for (int i = 0; i < N; i++) m_br[i] = (i == pos_of(m_ph)) ? MAXB : m_br[i] / 2;
`endif
        m_led = l;
    endtask

    task automatic adv();
        @(posedge hwclk);
        if (rst_n) model_edge(); else model_reset();
        #1;
    endtask

    task automatic wait_step(output bit ok);
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            adv();
            ok = bus.step;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; bus.enable = 1; bus.wrap_mode = 0;
        #1;
        model_reset();
        adv(); adv();
        rst_n = 1;
    endtask

    task automatic test_reset();
        bus.enable = 1; bus.wrap_mode = 0;
        #1 rst_n = 0;
        #1;
        model_reset();
        n_tests += 3;
        if (bus.led !== '0) begin n_fail++; $display("FAIL reset_led got %h want 0", bus.led); end
        if (bus.pos !== '0) begin n_fail++; $display("FAIL reset_pos got %0d want 0", bus.pos); end
        if (bus.step !== 1'b0) begin n_fail++; $display("FAIL reset_step got %b want 0", bus.step); end
        adv(); adv();
        rst_n = 1;
        for (int c = 1; c <= 4; c++) begin
            adv();
            n_tests += 2;
            if (bus.step !== (c == 4)) begin n_fail++; $display("FAIL first_step cyc %0d got %b want %b", c, bus.step, c == 4); end
            if (int'(bus.pos) !== (c == 4 ? 1 : 0)) begin n_fail++; $display("FAIL first_pos cyc %0d got %0d", c, bus.pos); end
            if (c == 1) begin
                n_tests++;
                if (bus.led !== 8'h01) begin n_fail++; $display("FAIL first_led got %h want 01", bus.led); end
            end
        end
    endtask

    task automatic test_bounce();
        int exp_seq [14] = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        bit ok;
        for (int k = 0; k < 14; k++) begin
            wait_step(ok);
            n_tests++;
            if (!ok || int'(bus.pos) !== exp_seq[k]) begin
                n_fail++; $display("FAIL bounce_seq tick %0d got %0d (step_seen %b) want %0d", k, bus.pos, ok, exp_seq[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_seq [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        int sw_seq [3] = '{4, 5, 6};
        bit ok;
        do_reset();
        bus.wrap_mode = 1;
        for (int k = 0; k < 8; k++) begin
            wait_step(ok);
            n_tests++;
            if (!ok || int'(bus.pos) !== exp_seq[k]) begin
                n_fail++; $display("FAIL wrap_seq tick %0d got %0d want %0d", k, bus.pos, exp_seq[k]);
            end
        end
        do_reset();
        for (int k = 0; k < 11; k++) wait_step(ok);
        n_tests++;
        if (!ok || bus.pos !== 3'd3) begin n_fail++; $display("FAIL pre_switch_pos got %0d want 3", bus.pos); end
        for (int k = 0; k < 3; k++) begin
            bus.wrap_mode = (k == 0);
            wait_step(ok);
            n_tests++;
            if (!ok || int'(bus.pos) !== sw_seq[k]) begin
                n_fail++; $display("FAIL mode_switch %0d got %0d want %0d", k, bus.pos, sw_seq[k]);
            end
        end
        bus.wrap_mode = 0;
    endtask

    task automatic test_tail_duty();
`ifdef LARSEN_TAIL_EN
        int exp_on [4] = '{1, 3, 7, 15};
`else
        int exp_on [4] = '{0, 0, 0, 16};
`endif
        int cnt [4] = '{0, 0, 0, 0};
        bit ok;
        do_reset();
        for (int k = 0; k < 3; k++) wait_step(ok);
        bus.enable = 0;
        adv();
        for (int c = 0; c < 16; c++) begin
            adv();
            for (int i = 0; i < 4; i++) cnt[i] += int'(bus.led[i]);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (cnt[i] !== exp_on[i]) begin n_fail++; $display("FAIL duty_led%0d got %0d want %0d", i, cnt[i], exp_on[i]); end
        end
        bus.enable = 1;
    endtask

    task automatic test_freeze();
        bit ok;
        int steps = 0, moved = 0, bad_led = 0, lat = 0;
        logic [2:0] p0;
        do_reset();
        wait_step(ok);
        wait_step(ok);
        adv(); adv();
        p0 = bus.pos;
        bus.enable = 0;
        for (int c = 0; c < 100; c++) begin
            adv();
            steps += int'(bus.step);
            moved += int'(bus.pos !== p0);
            bad_led += int'(bus.led !== m_led);
        end
        n_tests += 3;
        if (steps != 0) begin n_fail++; $display("FAIL freeze_step got %0d pulses want 0", steps); end
        if (moved != 0) begin n_fail++; $display("FAIL freeze_pos moved %0d cycles want 0", moved); end
        if (bad_led != 0) begin n_fail++; $display("FAIL freeze_led got %0d bad cycles want 0", bad_led); end
        bus.enable = 1;
        ok = 0;
        for (int c = 0; c < 64 && !ok; c++) begin adv(); lat++; ok = bus.step; end
        n_tests++;
        if (!ok || lat != 2) begin n_fail++; $display("FAIL resume_latency got %0d want 2", lat); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int lat = 0;
        do_reset();
        for (int k = 0; k < 9; k++) wait_step(ok);
        n_tests++;
        if (bus.pos !== 3'd5) begin n_fail++; $display("FAIL pre_reset_pos got %0d want 5", bus.pos); end
        adv();
        #2 rst_n = 0;
        #1;
        model_reset();
        n_tests += 3;
        if (bus.pos !== '0) begin n_fail++; $display("FAIL async_pos got %0d want 0", bus.pos); end
        if (bus.led !== '0) begin n_fail++; $display("FAIL async_led got %h want 0", bus.led); end
        if (bus.step !== 1'b0) begin n_fail++; $display("FAIL async_step got %b want 0", bus.step); end
        adv();
        rst_n = 1;
        ok = 0;
        for (int c = 0; c < 64 && !ok; c++) begin adv(); lat++; ok = bus.step; end
        n_tests++;
        if (!ok || lat != 4 || bus.pos !== 3'd1) begin n_fail++; $display("FAIL restart got lat %0d pos %0d want lat 4 pos 1", lat, bus.pos); end
        wait_step(ok);
        n_tests++;
        if (!ok || bus.pos !== 3'd2) begin n_fail++; $display("FAIL restart_up got %0d want 2", bus.pos); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.enable = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) bus.wrap_mode = ~bus.wrap_mode;
            if (!rst_n) rst_n = 1;
            else if ($urandom % 300 == 0) begin rst_n = 0; model_reset(); end
            adv();
            n_tests += 3;
            if (bus.led !== m_led) begin n_fail++; $display("FAIL rand_led cyc %0d got %h want %h", c, bus.led, m_led); end
            if (int'(bus.pos) !== pos_of(m_ph)) begin n_fail++; $display("FAIL rand_pos cyc %0d got %0d want %0d", c, bus.pos, pos_of(m_ph)); end
            if (bus.step !== m_step) begin n_fail++; $display("FAIL rand_step cyc %0d got %b want %b", c, bus.step, m_step); end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_tail_duty();
        test_freeze();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
